// File: rtl/rf_commit_ctrl_pkg.sv
// rtl/rf_commit_ctrl_pkg.sv - shared constants, FSM encoding and commit entry type for rf_commit_ctrl
package rf_commit_ctrl_pkg;

    localparam int REG_NUM_WIDTH  = 5;
    localparam int ROB_SIZE_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [REG_NUM_WIDTH-1:0]  rd;
        logic [31:0]               value;
        logic [ROB_SIZE_WIDTH-1:0] tag;
    } commit_entry_t;

endpackage

// File: rtl/rf_commit_ctrl_commit_fifo.sv
// rtl/rf_commit_ctrl_commit_fifo.sv - commit buffer FIFO (push/pop/count/head) for rf_commit_ctrl
//
// Ports:
//   clk_in        clock, rising edge
//   rst_n_in      asynchronous active-low reset (pointers, count, storage cleared)
//   en_in         global enable; low freezes all state
//   push_in       write push_data_in at the tail
//   push_data_in  entry to store
//   pop_in        drop the head entry
//   head_out      current head entry (valid when count_out != 0)
//   count_out     number of stored entries, 0..DEPTH
module commit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] head_out,
    output logic [CNT_W-1:0] count_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en_in) begin
            if (push_in) begin
                mem[wr_ptr] <= push_data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_in) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_in, pop_in})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_out  = mem[rd_ptr];
    assign count_out = count;

endmodule

// File: rtl/rf_commit_ctrl.sv
// rtl/rf_commit_ctrl.sv - ROB-to-register-file commit controller with flush sequencing
//
// Optional feature macro: RF_COMMIT_BYPASS_EN (same-cycle write when the buffer is empty).
//
// Ports:
//   clk_in, rst_n_in          clock (rising edge), asynchronous active-low reset
//   rdy_in                    global enable; low freezes state and silences strobes
//   is_flush_in               mispredict flush request from the ROB
//   rob_valid_in/rd/value/tag ROB head commit offer
//   rob_ready_out             offer accepted this cycle when high with rob_valid_in
//   rf_valid_out/rd/value/dependency  register-file write port
//   rf_flush_out              register-file flush strobe
//   busy_out                  high while draining or flushing
module rf_commit_ctrl
    import rf_commit_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FLUSH_HOLD = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      is_flush_in,
    input  logic                      rob_valid_in,
    input  logic [REG_NUM_WIDTH-1:0]  rob_rd_in,
    input  logic [31:0]               rob_value_in,
    input  logic [ROB_SIZE_WIDTH-1:0] rob_tag_in,
    output logic                      rob_ready_out,
    output logic                      rf_valid_out,
    output logic [REG_NUM_WIDTH-1:0]  rf_rd_out,
    output logic [31:0]               rf_value_out,
    output logic [ROB_SIZE_WIDTH-1:0] rf_dependency_out,
    output logic                      rf_flush_out,
    output logic                      busy_out
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = $bits(commit_entry_t);
    localparam int HOLD_W  = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FLUSH_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]    count;
    logic [ENTRY_W-1:0]  head_bits;
    commit_entry_t       head;
    commit_entry_t       in_entry;
    logic                ready_int;
    logic                accept_nz;
    logic                push;
    logic                pop;
    logic                bypass;

    assign in_entry = {rob_rd_in, rob_value_in, rob_tag_in};
    assign head     = commit_entry_t'(head_bits);

    // rst_n_in is folded in so ready stays low while reset is held, not only after the first edge.
    assign ready_int = rst_n_in && rdy_in && (state == ST_RUN) && (count < CNT_FULL) && !is_flush_in;
    // Writes to r0 are architecturally discarded, so they are accepted but never buffered.
    assign accept_nz = rob_valid_in && ready_int && (rob_rd_in != '0);
    // Head is written and retired in the same cycle whenever the buffer is non-empty.
    assign pop       = rdy_in && (count != '0);

`ifdef RF_COMMIT_BYPASS_EN
    assign bypass = accept_nz && (count == '0);
`else
    assign bypass = 1'b0;
`endif
    assign push = accept_nz && !bypass;

    commit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .en_in        (rdy_in),
        .push_in      (push),
        .push_data_in (in_entry),
        .pop_in       (pop),
        .head_out     (head_bits),
        .count_out    (count)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_RUN;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hold_cnt <= '0;
        end else if (rdy_in) begin
            if ((state == ST_FLUSH) && (hold_cnt != HOLD_LAST)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (is_flush_in) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // No pushes happen here and the head pops every cycle, so count <= 1
                // means the buffer is empty after this edge.
                if (count <= CNT_W'(1)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        rob_ready_out     = ready_int;
        rf_valid_out      = pop || bypass;
        rf_rd_out         = '0;
        rf_value_out      = '0;
        rf_dependency_out = '0;
        if (pop) begin
            rf_rd_out         = head.rd;
            rf_value_out      = head.value;
            rf_dependency_out = head.tag;
        end else if (bypass) begin
            rf_rd_out         = in_entry.rd;
            rf_value_out      = in_entry.value;
            rf_dependency_out = in_entry.tag;
        end
        // The buffer is always empty in FLUSH, so this never coincides with a write.
        rf_flush_out      = rdy_in && (state == ST_FLUSH);
        busy_out          = (state != ST_RUN);
    end

endmodule

// File: tb/tb_rf_commit_ctrl.sv
// tb/tb_rf_commit_ctrl.sv - directed self-checking bench for rf_commit_ctrl
module tb_rf_commit_ctrl;
    import rf_commit_ctrl_pkg::*;

    logic                      clk_in;
    logic                      rst_n_in;
    logic                      rdy_in;
    logic                      is_flush_in;
    logic                      rob_valid_in;
    logic [REG_NUM_WIDTH-1:0]  rob_rd_in;
    logic [31:0]               rob_value_in;
    logic [ROB_SIZE_WIDTH-1:0] rob_tag_in;
    logic                      rob_ready_out;
    logic                      rf_valid_out;
    logic [REG_NUM_WIDTH-1:0]  rf_rd_out;
    logic [31:0]               rf_value_out;
    logic [ROB_SIZE_WIDTH-1:0] rf_dependency_out;
    logic                      rf_flush_out;
    logic                      busy_out;

    int n_tests = 0;
    int n_fail  = 0;

    rf_commit_ctrl #(.FIFO_DEPTH(4), .FLUSH_HOLD(1)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .rdy_in            (rdy_in),
        .is_flush_in       (is_flush_in),
        .rob_valid_in      (rob_valid_in),
        .rob_rd_in         (rob_rd_in),
        .rob_value_in      (rob_value_in),
        .rob_tag_in        (rob_tag_in),
        .rob_ready_out     (rob_ready_out),
        .rf_valid_out      (rf_valid_out),
        .rf_rd_out         (rf_rd_out),
        .rf_value_out      (rf_value_out),
        .rf_dependency_out (rf_dependency_out),
        .rf_flush_out      (rf_flush_out),
        .busy_out          (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs for the new cycle are driven here.
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input logic v, input logic [REG_NUM_WIDTH-1:0] rd,
                         input logic [31:0] val, input logic [ROB_SIZE_WIDTH-1:0] tag);
        rob_valid_in = v;
        rob_rd_in    = rd;
        rob_value_in = val;
        rob_tag_in   = tag;
    endtask

    initial begin
        rst_n_in    = 1'b0;
        rdy_in      = 1'b1;
        is_flush_in = 1'b0;
        offer(1'b0, '0, '0, '0);

        // Reset state
        #2;
        chk("rst_ready", rob_ready_out, 0);
        chk("rst_valid", rf_valid_out, 0);
        chk("rst_flush", rf_flush_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_rd", rf_rd_out, 0);
        cyc();
        cyc();
        rst_n_in = 1'b1;
        #1;
        chk("rel_ready", rob_ready_out, 1);

`ifdef RF_COMMIT_BYPASS_EN
        cyc();
        offer(1'b1, 5'd5, 32'hDEADBEEF, 4'd3);
        #1;
        chk("byp_valid", rf_valid_out, 1);
        chk("byp_rd", rf_rd_out, 5);
        chk("byp_value", rf_value_out, 32'hDEADBEEF);
        chk("byp_dep", rf_dependency_out, 3);
        cyc();
        offer(1'b0, '0, '0, '0);
        #1;
        chk("byp_after", rf_valid_out, 0);
`else
        // Single commit, one-cycle latency
        cyc();
        offer(1'b1, 5'd5, 32'hDEADBEEF, 4'd3);
        #1;
        chk("c1_ready", rob_ready_out, 1);
        chk("c1_valid_n", rf_valid_out, 0);
        cyc();
        offer(1'b0, '0, '0, '0);
        #1;
        chk("c1_valid", rf_valid_out, 1);
        chk("c1_rd", rf_rd_out, 5);
        chk("c1_value", rf_value_out, 32'hDEADBEEF);
        chk("c1_dep", rf_dependency_out, 3);
        cyc();
        #1;
        chk("c1_idle", rf_valid_out, 0);

        // Burst of six back-to-back commits
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (i < 6) offer(1'b1, 5'(i + 1), 32'h100 + 32'(i), 4'(i));
            else       offer(1'b0, '0, '0, '0);
            #1;
            if (i < 6) chk("burst_ready", rob_ready_out, 1);
            chk("burst_valid", rf_valid_out, (i > 0) ? 1 : 0);
            if (i > 0) begin
                chk("burst_rd", rf_rd_out, i);
                chk("burst_value", rf_value_out, 32'h100 + 32'(i - 1));
            end
        end

        // rd == 0 accepted and dropped
        cyc();
        offer(1'b1, 5'd0, 32'h1234, 4'd1);
        #1;
        chk("r0_ready", rob_ready_out, 1);
        cyc();
        offer(1'b0, '0, '0, '0);
        #1;
        chk("r0_valid", rf_valid_out, 0);

        // Three commits, then flush: writes finish, drain, one-cycle flush pulse
        for (int i = 0; i < 3; i++) begin
            cyc();
            offer(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 4'(i));
        end
        cyc();
        offer(1'b1, 5'd30, 32'hBAD, 4'd9);
        is_flush_in = 1'b1;
        #1;
        chk("fl_ready_n", rob_ready_out, 0);
        chk("fl_last_wr", rf_valid_out, 1);
        chk("fl_last_rd", rf_rd_out, 12);
        chk("fl_busy0", busy_out, 0);
        cyc();
        offer(1'b1, 5'd20, 32'h20, 4'd2);
        #1;
        chk("drain_busy", busy_out, 1);
        chk("drain_ready", rob_ready_out, 0);
        chk("drain_valid", rf_valid_out, 0);
        chk("drain_flush", rf_flush_out, 0);
        cyc();
        #1;
        chk("flush_pulse", rf_flush_out, 1);
        chk("flush_busy", busy_out, 1);
        chk("flush_valid", rf_valid_out, 0);
        chk("flush_ready", rob_ready_out, 0);
        cyc();
        is_flush_in = 1'b0;
        offer(1'b0, '0, '0, '0);
        #1;
        chk("post_flush", rf_flush_out, 0);
        chk("post_busy", busy_out, 0);
        chk("post_ready", rob_ready_out, 1);
        cyc();
        #1;
        chk("post_nowr", rf_valid_out, 0);
        chk("post_noflush", rf_flush_out, 0);

        // rdy_in low freezes a pending write
        cyc();
        offer(1'b1, 5'd7, 32'h77, 4'd7);
        cyc();
        offer(1'b1, 5'd8, 32'h88, 4'd8);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_valid", rf_valid_out, 0);
            chk("frz_ready", rob_ready_out, 0);
            cyc();
        end
        rdy_in = 1'b1;
        offer(1'b0, '0, '0, '0);
        #1;
        chk("frz_resume", rf_valid_out, 1);
        chk("frz_rd", rf_rd_out, 7);
        cyc();
        #1;
        chk("frz_dropped", rf_valid_out, 0);
`endif

        // Reset asserted while in DRAIN
        cyc();
        offer(1'b1, 5'd9, 32'h99, 4'd9);
        cyc();
        offer(1'b0, '0, '0, '0);
        is_flush_in = 1'b1;
        cyc();
        is_flush_in = 1'b0;
        #1;
        chk("mid_busy", busy_out, 1);
        rst_n_in = 1'b0;
        #1;
        chk("ar_busy", busy_out, 0);
        chk("ar_ready", rob_ready_out, 0);
        chk("ar_valid", rf_valid_out, 0);
        chk("ar_flush", rf_flush_out, 0);
        cyc();
        rst_n_in = 1'b1;
        #1;
        chk("ar_rel_ready", rob_ready_out, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("ar_noflush", rf_flush_out, 0);
            chk("ar_nobusy", busy_out, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_commit_ctrl.md
RF_COMMIT_CTRL -- requirements
Module: rf_commit_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning commit-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter FLUSH_HOLD, default 1, meaning cycles rf_flush_out stays high per flush.
REQ-003 SHALL have ports: clk_in  input  1  clock, the single clock; all state on rising edge.
REQ-004 SHALL have ports: rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: rdy_in  input  1  global enable; low freezes all state.
REQ-006 SHALL have ports: is_flush_in  input  1  mispredict flush request from ROB.
REQ-007 SHALL have ports: rob_valid_in  input  1  ROB head commit offered.
REQ-008 SHALL have ports: rob_rd_in  input  REG_NUM_WIDTH  destination register.
REQ-009 SHALL have ports: rob_value_in  input  32  result value.
REQ-010 SHALL have ports: rob_tag_in  input  ROB_SIZE_WIDTH  ROB index of entry.
REQ-011 SHALL have ports: rob_ready_out  output  1  commit accepted this cycle when high with rob_valid_in.
REQ-012 SHALL have ports: rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out  output  1/REG_NUM_WIDTH/32/ROB_SIZE_WIDTH  register-file write port.
REQ-013 SHALL have ports: rf_flush_out  output  1  drives register-file flush input.
REQ-014 SHALL have ports: busy_out  output  1  high in DRAIN or FLUSH.

Function
REQ-015 SHALL implement FSM states RUN, DRAIN, FLUSH.
REQ-016 RUN: rob_ready_out = (count < FIFO_DEPTH) and not is_flush_in; count from registered state only.
REQ-017 Accepted entry with rd != 0 SHALL push {rd,value,tag} into FIFO; rd == 0 SHALL be accepted and dropped.
REQ-018 Non-empty FIFO SHALL present head on rf_* outputs with rf_valid_out high and pop it the same cycle; one write per cycle.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-020 Baseline latency: accept in cycle N -> rf_valid_out in cycle N+1; order preserved.
REQ-021 is_flush_in high in RUN SHALL go to DRAIN; entry offered that cycle is NOT accepted.
REQ-022 DRAIN: rob_ready_out low, FIFO keeps popping; when count reaches 0 -> FLUSH next cycle (immediately if already empty).
REQ-023 FLUSH: rf_flush_out high for FLUSH_HOLD cycles, rf_valid_out low, then -> RUN.
REQ-024 is_flush_in during DRAIN/FLUSH SHALL be ignored (no restart, no extra pulse).
REQ-025 rf_valid_out and rf_flush_out SHALL never be high together.
REQ-026 rdy_in low SHALL hold FSM, FIFO, counters; rf_valid_out, rf_flush_out, rob_ready_out forced low.

Reset
REQ-027 rst_n_in low SHALL asynchronously set state RUN, count 0, pointers 0, all outputs 0 except rob_ready_out which reflects RUN/empty only after reset release.
REQ-028 Reset mid-DRAIN/FLUSH SHALL discard FIFO contents and suppress pending rf_flush_out.

Configuration
REQ-029 Macro RF_COMMIT_BYPASS_EN defined: in RUN with empty FIFO, accepted entry SHALL appear on rf_* the same cycle (combinational, latency 0) without entering FIFO.
REQ-030 Macro undefined: no bypass path; all writes take REQ-020 latency.

Structure
REQ-031 REG_NUM_WIDTH, ROB_SIZE_WIDTH and the FSM state encoding SHALL live in the shared constants include; no local redefinition.
REQ-032 FIFO SHALL be one sub-module commit_fifo (push/pop/count/head, async active-low reset); FSM and bypass stay in rf_commit_ctrl.

Verification
REQ-033 Single commit rd=5, value=0xDEADBEEF, tag=3 -> next cycle rf_valid_out=1, rf_rd_out=5, rf_value_out=0xDEADBEEF, rf_dependency_out=3.
REQ-034 Hold rf path blocked? no -- burst 6 back-to-back commits -> all six written in order, one per cycle, ready never drops.
REQ-035 Commit rd=0, value=0x1234 -> accepted, rf_valid_out stays 0.
REQ-036 Three entries buffered, is_flush_in pulse -> three writes complete, then rf_flush_out=1 one cycle, busy_out covers both phases, then ready returns.
REQ-037 rdy_in low 3 cycles with 2 buffered -> no writes, no state change; writes resume on rdy_in high.
REQ-038 rst_n_in low mid-DRAIN -> outputs 0 asynchronously, no rf_flush_out after release; with RF_COMMIT_BYPASS_EN, commit into empty FIFO -> rf_valid_out same cycle.
